// File: rtl/lmem_port_arbiter_if.sv
// Requester and layer-memory port bundle for lmem_port_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory side.
interface lmem_port_arbiter_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 12,
    parameter int unsigned DW   = 20
);
    logic [NREQ-1:0]    rq_valid;
    logic [NREQ-1:0]    rq_we;
    logic [NREQ-1:0]    rq_lock;
    logic [3*NREQ-1:0]  rq_sel;
    logic [AW*NREQ-1:0] rq_addr;
    logic [DW*NREQ-1:0] rq_wdata;
    logic [NREQ-1:0]    rq_ready;
    logic [NREQ-1:0]    rs_valid;
    logic [DW-1:0]      rs_data;
    logic               cwr;
    logic               crd;
    logic [AW-1:0]      caddr_wr;
    logic [AW-1:0]      caddr_rd;
    logic [DW-1:0]      cdata_wr;
    logic [2:0]         csel;
    logic [DW-1:0]      cdata_rd;
    logic               idle;

    modport slave (
        input  rq_valid, rq_we, rq_lock, rq_sel, rq_addr, rq_wdata, cdata_rd,
        output rq_ready, rs_valid, rs_data, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, idle
    );

    modport master (
        output rq_valid, rq_we, rq_lock, rq_sel, rq_addr, rq_wdata, cdata_rd,
        input  rq_ready, rs_valid, rs_data, cwr, crd, caddr_wr, caddr_rd, cdata_wr, csel, idle
    );
endinterface

// File: rtl/lmem_port_arbiter.sv
// Round-robin arbiter sharing the single layer-memory port between CNN engines,
// with burst locking and read-data routing back to the issuing engine.
module lmem_port_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 12,
    parameter int unsigned DW   = 20
) (
    input logic               clk,
    input logic               reset,
    lmem_port_arbiter_if.slave bus
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    logic [IW-1:0]   rr_ptr_q;
    logic            lock_valid_q;
    logic [IW-1:0]   lock_id_q;
    logic [IW-1:0]   iss_id_q;
    logic            rd_valid_q;
    logic [IW-1:0]   rd_id_q;
    logic            cwr_q;
    logic            crd_q;
    logic [AW-1:0]   caddr_wr_q;
    logic [AW-1:0]   caddr_rd_q;
    logic [DW-1:0]   cdata_wr_q;
    logic [2:0]      csel_q;

    logic [NREQ-1:0] grant;
    logic [IW-1:0]   gnt_id;
    logic            accept;
    logic            found;
    logic [IW:0]     scan;
    logic [IW-1:0]   rr_ptr_d;
    logic            gnt_we;
    logic            gnt_lock;
    logic [2:0]      gnt_sel;
    logic [AW-1:0]   gnt_addr;
    logic [DW-1:0]   gnt_wdata;

    // Grant depends only on registered state and rq_valid.
    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        scan   = '0;
        if (lock_valid_q) begin
            if (bus.rq_valid[lock_id_q]) begin
                grant[lock_id_q] = 1'b1;
                gnt_id           = lock_id_q;
            end
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                scan = {1'b0, rr_ptr_q} + (IW+1)'(k);
                if (scan >= (IW+1)'(NREQ)) begin
                    scan = scan - (IW+1)'(NREQ);
                end
                if (!found && bus.rq_valid[scan[IW-1:0]]) begin
                    found                  = 1'b1;
                    grant[scan[IW-1:0]]    = 1'b1;
                    gnt_id                 = scan[IW-1:0];
                end
            end
        end
        if (reset) begin
            grant = '0;
        end
    end

    assign accept    = |grant;
    assign gnt_we    = bus.rq_we[gnt_id];
    assign gnt_lock  = bus.rq_lock[gnt_id];
    assign gnt_sel   = bus.rq_sel[32'(gnt_id) * 3 +: 3];
    assign gnt_addr  = bus.rq_addr[32'(gnt_id) * AW +: AW];
    assign gnt_wdata = bus.rq_wdata[32'(gnt_id) * DW +: DW];
    assign rr_ptr_d  = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            iss_id_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_id_q      <= '0;
            cwr_q        <= 1'b0;
            crd_q        <= 1'b0;
            caddr_wr_q   <= '0;
            caddr_rd_q   <= '0;
            cdata_wr_q   <= '0;
            csel_q       <= '0;
        end else begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            // Read data from the memory lands one cycle after crd.
            rd_valid_q <= crd_q;
            rd_id_q    <= iss_id_q;
            if (accept) begin
                iss_id_q <= gnt_id;
                csel_q   <= gnt_sel;
                if (gnt_we) begin
                    cwr_q      <= 1'b1;
                    caddr_wr_q <= gnt_addr;
                    cdata_wr_q <= gnt_wdata;
                end else begin
                    crd_q      <= 1'b1;
                    caddr_rd_q <= gnt_addr;
                end
                if (gnt_lock) begin
                    lock_valid_q <= 1'b1;
                    lock_id_q    <= gnt_id;
                end else begin
                    lock_valid_q <= 1'b0;
                    rr_ptr_q     <= rr_ptr_d;
                end
            end
        end
    end

    always_comb begin
        bus.rs_valid = '0;
        if (rd_valid_q) begin
            bus.rs_valid[rd_id_q] = 1'b1;
        end
    end

    assign bus.rq_ready = grant;
    assign bus.rs_data  = rd_valid_q ? bus.cdata_rd : '0;
    assign bus.cwr      = cwr_q;
    assign bus.crd      = crd_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.csel     = csel_q;
    assign bus.idle     = !reset && !lock_valid_q && !crd_q && !rd_valid_q;
endmodule

// File: tb/tb_lmem_port_arbiter.sv
// Bench for lmem_port_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-indexed timeline model of grants, memory strobes and read returns.
module tb_lmem_port_arbiter;
    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 12;
    localparam int unsigned DW   = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lmem_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    lmem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit             we;
        logic [2:0]     sel;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
    } beat_t;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Timeline model: what the memory port and return path show in a given cycle.
    beat_t issue_at[int];
    int    rs_at[int];
    int    m_rr;
    bit    m_lock;
    int    m_owner;

    function automatic int model_grant();
        if (reset) return -1;
        if (m_lock) return bus.rq_valid[m_owner] ? m_owner : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (bus.rq_valid[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        issue_at.delete();
        rs_at.delete();
        m_rr    = 0;
        m_lock  = 1'b0;
        m_owner = 0;
    endfunction

    task automatic tick();
        int    g;
        beat_t b;
        bit    lk;
        g = model_grant();
        if (g >= 0) begin
            b.we    = bus.rq_we[g];
            b.sel   = bus.rq_sel[3*g +: 3];
            b.addr  = bus.rq_addr[AW*g +: AW];
            b.wdata = bus.rq_wdata[DW*g +: DW];
            lk      = bus.rq_lock[g];
        end
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            issue_at[cyc] = b;
            if (!b.we) rs_at[cyc + 1] = g;
            if (lk) begin
                m_lock  = 1'b1;
                m_owner = g;
            end else begin
                m_lock = 1'b0;
                m_rr   = (g + 1) % NREQ;
            end
        end
        if (reset) model_clear();
        #1;
    endtask

    task automatic clear_inputs();
        bus.rq_valid = '0;
        bus.rq_we    = '0;
        bus.rq_lock  = '0;
        bus.rq_sel   = '0;
        bus.rq_addr  = '0;
        bus.rq_wdata = '0;
        bus.cdata_rd = '0;
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input bit lk,
                           input logic [2:0] sel, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata);
        bus.rq_valid[i]          = v;
        bus.rq_we[i]             = we;
        bus.rq_lock[i]           = lk;
        bus.rq_sel[3*i +: 3]     = sel;
        bus.rq_addr[AW*i +: AW]  = addr;
        bus.rq_wdata[DW*i +: DW] = wdata;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.rq_valid = '1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.rq_ready !== 3'b000) begin
            errors++; $display("FAIL reset_ready: got %b want 000", bus.rq_ready);
        end
        checks++;
        if ({bus.cwr, bus.crd, bus.rs_valid, bus.idle} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: cwr=%b crd=%b rs_valid=%b idle=%b want all 0",
                     bus.cwr, bus.crd, bus.rs_valid, bus.idle);
        end
        checks++;
        if ({bus.caddr_wr, bus.caddr_rd, bus.cdata_wr, bus.csel} !== '0) begin
            errors++; $display("FAIL reset_bus: address/data/csel not 0");
        end
        reset = 1'b0;
        clear_inputs();
        model_clear();
        #1;
        checks++;
        if (bus.idle !== 1'b1) begin
            errors++; $display("FAIL reset_idle_after: got %b want 1", bus.idle);
        end
    endtask

    task automatic test_single_read();
        apply_reset();
        set_req(1, 1'b1, 1'b0, 1'b0, 3'd1, 12'h005, '0);
        #1;
        checks++;
        if (bus.rq_ready !== 3'b010) begin
            errors++; $display("FAIL single_read_grant: got %b want 010", bus.rq_ready);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.crd !== 1'b1 || bus.cwr !== 1'b0 || bus.caddr_rd !== 12'h005
            || bus.csel !== 3'd1) begin
            errors++;
            $display("FAIL single_read_issue: crd=%b cwr=%b caddr_rd=%h csel=%0d want 1 0 005 1",
                     bus.crd, bus.cwr, bus.caddr_rd, bus.csel);
        end
        tick();
        bus.cdata_rd = 20'h0ABCD;
        #1;
        checks++;
        if (bus.rs_valid !== 3'b010 || bus.rs_data !== 20'h0ABCD) begin
            errors++;
            $display("FAIL single_read_return: rs_valid=%b rs_data=%h want 010 0abcd",
                     bus.rs_valid, bus.rs_data);
        end
        tick();
        checks++;
        if (bus.rs_valid !== 3'b000 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL single_read_done: rs_valid=%b idle=%b want 000 1",
                     bus.rs_valid, bus.idle);
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] wd [NREQ];
        logic [NREQ-1:0] exp;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            wd[i] = DW'(20'h10000 + i);
            set_req(i, 1'b1, 1'b1, 1'b0, 3'(i), AW'(i), wd[i]);
        end
        for (int k = 0; k < 6; k++) begin
            #1;
            exp = '0;
            exp[k % NREQ] = 1'b1;
            checks++;
            if (bus.rq_ready !== exp) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.rq_ready, exp);
            end
            tick();
            checks++;
            if (bus.cwr !== 1'b1 || bus.cdata_wr !== wd[k % NREQ]) begin
                errors++;
                $display("FAIL rr_write[%0d]: cwr=%b cdata_wr=%h want 1 %h",
                         k, bus.cwr, bus.cdata_wr, wd[k % NREQ]);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_lock_burst();
        logic [NREQ-1:0] exp_rs;
        apply_reset();
        // One unlocked beat from requester 0 moves priority to requester 1.
        set_req(0, 1'b1, 1'b1, 1'b0, 3'd0, 12'h100, 20'h00001);
        #1;
        tick();
        for (int b = 0; b < 7; b++) begin
            if (b < 4) set_req(1, 1'b1, 1'b0, (b < 3), 3'd1, AW'(12'h020 + b), '0);
            else       set_req(1, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
            set_req(0, (b < 5), 1'b1, 1'b0, 3'd0, 12'h100, 20'h00002);
            bus.cdata_rd = DW'($urandom);
            #1;
            if (b <= 4) begin
                checks++;
                if (bus.rq_ready !== ((b < 4) ? 3'b010 : 3'b001)) begin
                    errors++;
                    $display("FAIL lock_grant[%0d]: got %b want %b", b, bus.rq_ready,
                             (b < 4) ? 3'b010 : 3'b001);
                end
            end
            exp_rs = (b >= 2 && b <= 5) ? 3'b010 : 3'b000;
            checks++;
            if (bus.rs_valid !== exp_rs || (exp_rs != 0 && bus.rs_data !== bus.cdata_rd)) begin
                errors++;
                $display("FAIL lock_return[%0d]: rs_valid=%b rs_data=%h want %b %h",
                         b, bus.rs_valid, bus.rs_data, exp_rs, bus.cdata_rd);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_locked_stall();
        apply_reset();
        set_req(2, 1'b1, 1'b1, 1'b1, 3'd2, 12'h222, 20'h22222);
        #1;
        tick();
        set_req(2, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        set_req(0, 1'b1, 1'b1, 1'b0, 3'd0, 12'h001, 20'h00011);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (bus.rq_ready !== 3'b000 || bus.idle !== 1'b0) begin
                errors++;
                $display("FAIL stall_grant[%0d]: rq_ready=%b idle=%b want 000 0",
                         k, bus.rq_ready, bus.idle);
            end
            tick();
            checks++;
            if (bus.cwr !== 1'b0 || bus.crd !== 1'b0) begin
                errors++;
                $display("FAIL stall_port[%0d]: cwr=%b crd=%b want 0 0", k, bus.cwr, bus.crd);
            end
        end
        set_req(2, 1'b1, 1'b1, 1'b0, 3'd2, 12'h223, 20'h22223);
        #1;
        checks++;
        if (bus.rq_ready !== 3'b100) begin
            errors++; $display("FAIL stall_release: got %b want 100", bus.rq_ready);
        end
        tick();
        set_req(2, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0);
        #1;
        checks++;
        if (bus.rq_ready !== 3'b001) begin
            errors++; $display("FAIL stall_after: got %b want 001", bus.rq_ready);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_pointer_wrap();
        apply_reset();
        set_req(1, 1'b1, 1'b1, 1'b0, 3'd1, 12'h011, 20'h00011);
        #1;
        tick();
        clear_inputs();
        set_req(0, 1'b1, 1'b1, 1'b0, 3'd0, 12'h000, 20'h00000);
        set_req(2, 1'b1, 1'b1, 1'b0, 3'd2, 12'h002, 20'h00002);
        #1;
        checks++;
        if (bus.rq_ready !== 3'b100) begin
            errors++; $display("FAIL wrap_first: got %b want 100", bus.rq_ready);
        end
        tick();
        checks++;
        if (bus.rq_ready !== 3'b001) begin
            errors++; $display("FAIL wrap_second: got %b want 001", bus.rq_ready);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        set_req(1, 1'b1, 1'b0, 1'b1, 3'd3, 12'h0F0, '0);
        #1;
        tick();
        clear_inputs();
        set_req(0, 1'b1, 1'b1, 1'b0, 3'd0, 12'h001, 20'h00001);
        bus.cdata_rd = 20'h12345;
        #1;
        checks++;
        if (bus.crd !== 1'b1) begin
            errors++; $display("FAIL midread_issue: crd=%b want 1", bus.crd);
        end
        reset = 1'b1;
        model_clear();
        #1;
        checks++;
        if ({bus.crd, bus.cwr, bus.rq_ready, bus.rs_valid, bus.idle} !== 9'b0
            || bus.caddr_rd !== '0 || bus.csel !== '0 || bus.rs_data !== '0) begin
            errors++;
            $display("FAIL midread_reset: crd=%b rq_ready=%b rs_valid=%b idle=%b caddr_rd=%h",
                     bus.crd, bus.rq_ready, bus.rs_valid, bus.idle, bus.caddr_rd);
        end
        tick();
        checks++;
        if (bus.rs_valid !== 3'b000) begin
            errors++; $display("FAIL midread_noreturn: rs_valid=%b want 000", bus.rs_valid);
        end
        reset = 1'b0;
        clear_inputs();
        #1;
        tick();
        checks++;
        if (bus.rs_valid !== 3'b000 || bus.idle !== 1'b1) begin
            errors++;
            $display("FAIL midread_release: rs_valid=%b idle=%b want 000 1",
                     bus.rs_valid, bus.idle);
        end
    endtask

    task automatic test_random();
        int              g;
        logic [NREQ-1:0] exp_ready;
        logic [NREQ-1:0] exp_rs;
        bit              exp_cwr;
        bit              exp_crd;
        bit              exp_idle;
        beat_t           b;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                set_req(i, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                        3'($urandom), AW'($urandom), DW'($urandom));
            end
            bus.cdata_rd = DW'($urandom);
            #1;
            g = model_grant();
            exp_ready = '0;
            if (g >= 0) exp_ready[g] = 1'b1;
            checks++;
            if (bus.rq_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, bus.rq_ready, exp_ready);
            end
            exp_cwr = issue_at.exists(cyc) && issue_at[cyc].we;
            exp_crd = issue_at.exists(cyc) && !issue_at[cyc].we;
            checks++;
            if (bus.cwr !== exp_cwr || bus.crd !== exp_crd) begin
                errors++;
                $display("FAIL rand_strobe[%0d]: cwr=%b crd=%b want %b %b",
                         n, bus.cwr, bus.crd, exp_cwr, exp_crd);
            end
            if (issue_at.exists(cyc)) begin
                b = issue_at[cyc];
                checks++;
                if (bus.csel !== b.sel
                    || (b.we && (bus.caddr_wr !== b.addr || bus.cdata_wr !== b.wdata))
                    || (!b.we && bus.caddr_rd !== b.addr)) begin
                    errors++;
                    $display("FAIL rand_issue[%0d]: csel=%0d caddr_wr=%h caddr_rd=%h cdata_wr=%h want sel=%0d addr=%h wdata=%h we=%b",
                             n, bus.csel, bus.caddr_wr, bus.caddr_rd, bus.cdata_wr,
                             b.sel, b.addr, b.wdata, b.we);
                end
            end
            exp_rs = '0;
            if (rs_at.exists(cyc)) exp_rs[rs_at[cyc]] = 1'b1;
            checks++;
            if (bus.rs_valid !== exp_rs || (exp_rs != 0 && bus.rs_data !== bus.cdata_rd)) begin
                errors++;
                $display("FAIL rand_return[%0d]: rs_valid=%b rs_data=%h want %b %h",
                         n, bus.rs_valid, bus.rs_data, exp_rs, bus.cdata_rd);
            end
            exp_idle = !m_lock && !exp_crd && !rs_at.exists(cyc);
            checks++;
            if (bus.idle !== exp_idle) begin
                errors++; $display("FAIL rand_idle[%0d]: got %b want %b", n, bus.idle, exp_idle);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        model_clear();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock_burst();
        test_locked_stall();
        test_pointer_wrap();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
